// File: rtl/i3c_sda_rx_frontend_if.sv
// Pad-side bus bundle for the I3C SDA receive front end: raw SCL/SDA and
// controls in, decoded conditions and received frames out.
interface i3c_sda_rx_frontend_if;
    logic       i_sda;
    logic       i_scl;
    logic       i_rx_en;
    logic       i_tbit_mode;
    logic       o_start_det;
    logic       o_rep_start_det;
    logic       o_stop_det;
    logic       o_bus_busy;
    logic [7:0] o_rx_byte;
    logic       o_rx_ninth;
    logic       o_rx_valid;
    logic       o_parity_err;
    logic       o_rx_abort;
    logic [3:0] o_bit_cnt;

    modport master (
        output i_sda, i_scl, i_rx_en, i_tbit_mode,
        input  o_start_det, o_rep_start_det, o_stop_det, o_bus_busy,
        input  o_rx_byte, o_rx_ninth, o_rx_valid, o_parity_err,
        input  o_rx_abort, o_bit_cnt
    );

    modport slave (
        input  i_sda, i_scl, i_rx_en, i_tbit_mode,
        output o_start_det, o_rep_start_det, o_stop_det, o_bus_busy,
        output o_rx_byte, o_rx_ninth, o_rx_valid, o_parity_err,
        output o_rx_abort, o_bit_cnt
    );
endinterface

// File: rtl/i3c_sda_rx_frontend.sv
// I3C receive front end: synchronises and deglitches SCL/SDA, detects
// START/Sr/STOP and deserialises 9-bit MSB-first frames.
module i3c_sda_rx_frontend #(
    parameter int SYNC_STAGES   = 2,
    parameter int GLITCH_CYCLES = 2
) (
    input logic                    i_sys_clk,
    input logic                    i_sys_rst,
    i3c_sda_rx_frontend_if.slave   bus
);

    typedef enum logic [1:0] {IDLE, DATA, NINTH} state_e;

    logic [1:0] raw_w;
    logic [1:0] filt_w;

    // Line 0 is SCL, line 1 is SDA; both share the same sync + deglitch path.
    assign raw_w = {bus.i_sda, bus.i_scl};

    for (genvar g = 0; g < 2; g++) begin : g_line
        logic [SYNC_STAGES-1:0] sync_q, sync_d;
        logic [3:0]             cnt_q, cnt_d;
        logic                   filt_q, filt_d;

        always_comb begin
            sync_d = {sync_q[SYNC_STAGES-2:0], raw_w[g]};
            cnt_d  = '0;
            filt_d = filt_q;
            if (sync_q[SYNC_STAGES-1] != filt_q) begin
                if (cnt_q == 4'(GLITCH_CYCLES - 1)) begin
                    filt_d = sync_q[SYNC_STAGES-1];
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
        end

        always_ff @(posedge i_sys_clk or negedge i_sys_rst) begin
            if (!i_sys_rst) begin
                sync_q <= '1;
                cnt_q  <= '0;
                filt_q <= 1'b1;
            end else begin
                sync_q <= sync_d;
                cnt_q  <= cnt_d;
                filt_q <= filt_d;
            end
        end

        assign filt_w[g] = filt_q;
    end

    logic scl_f, sda_f;
    logic scl_prev_q, scl_prev_d;
    logic sda_prev_q, sda_prev_d;

    assign scl_f = filt_w[0];
    assign sda_f = filt_w[1];

    always_comb begin
        scl_prev_d = scl_f;
        sda_prev_d = sda_f;
    end

    always_ff @(posedge i_sys_clk or negedge i_sys_rst) begin
        if (!i_sys_rst) begin
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_prev_q <= scl_prev_d;
            sda_prev_q <= sda_prev_d;
        end
    end

    logic scl_rise, scl_fall, sda_rise, sda_fall;
    logic cond_gate, start_c, rs_c, stop_c, any_cond;
    logic busy_q;

    assign scl_rise = scl_f & ~scl_prev_q;
    assign scl_fall = ~scl_f & scl_prev_q;
    assign sda_rise = sda_f & ~sda_prev_q;
    assign sda_fall = ~sda_f & sda_prev_q;

    // An SCL edge in the same cycle as an SDA edge masks the condition.
    assign cond_gate = scl_f & ~scl_rise & ~scl_fall;
    assign start_c   = cond_gate & sda_fall & ~busy_q;
    assign rs_c      = cond_gate & sda_fall & busy_q;
    assign stop_c    = cond_gate & sda_rise & busy_q;
    assign any_cond  = start_c | rs_c | stop_c;

    state_e     state_q;
    logic [7:0] shift_q;
    logic [3:0] bit_cnt_q;
    logic       ninth_q;
    logic       pend_q;
    logic       start_q, rs_q, stop_q, abort_q;
    logic [7:0] rx_byte_q;
    logic       rx_ninth_q, valid_q, perr_q;

    always_ff @(posedge i_sys_clk or negedge i_sys_rst) begin
        if (!i_sys_rst) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            ninth_q    <= 1'b0;
            pend_q     <= 1'b0;
            busy_q     <= 1'b0;
            start_q    <= 1'b0;
            rs_q       <= 1'b0;
            stop_q     <= 1'b0;
            abort_q    <= 1'b0;
            rx_byte_q  <= '0;
            rx_ninth_q <= 1'b0;
            valid_q    <= 1'b0;
            perr_q     <= 1'b0;
        end else begin
            start_q <= start_c;
            rs_q    <= rs_c;
            stop_q  <= stop_c;
            abort_q <= 1'b0;
            valid_q <= 1'b0;
            perr_q  <= 1'b0;
            pend_q  <= 1'b0;

            if (start_c) begin
                busy_q <= 1'b1;
            end else if (stop_c) begin
                busy_q <= 1'b0;
            end

            // A frame whose ninth bit was latched last cycle is published now.
            if (pend_q) begin
                rx_byte_q  <= shift_q;
                rx_ninth_q <= ninth_q;
                valid_q    <= 1'b1;
                perr_q     <= bus.i_tbit_mode & (ninth_q != (~^shift_q));
                bit_cnt_q  <= '0;
            end

            if (any_cond) begin
                abort_q   <= (state_q != IDLE) && !pend_q && (bit_cnt_q != 4'd0);
                bit_cnt_q <= '0;
                state_q   <= stop_c ? IDLE : DATA;
            end else if (!bus.i_rx_en) begin
                bit_cnt_q <= '0;
                if (state_q != IDLE) begin
                    state_q <= DATA;
                end
            end else begin
                case (state_q)
                    DATA: begin
                        if (scl_rise) begin
                            shift_q   <= {shift_q[6:0], sda_prev_q};
                            bit_cnt_q <= bit_cnt_q + 4'd1;
                            if (bit_cnt_q == 4'd7) begin
                                state_q <= NINTH;
                            end
                        end
                    end
                    NINTH: begin
                        if (scl_rise) begin
                            ninth_q <= sda_prev_q;
                            pend_q  <= 1'b1;
                            state_q <= DATA;
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.o_start_det     = start_q;
    assign bus.o_rep_start_det = rs_q;
    assign bus.o_stop_det      = stop_q;
    assign bus.o_bus_busy      = busy_q;
    assign bus.o_rx_byte       = rx_byte_q;
    assign bus.o_rx_ninth      = rx_ninth_q;
    assign bus.o_rx_valid      = valid_q;
    assign bus.o_parity_err    = perr_q;
    assign bus.o_rx_abort      = abort_q;
    assign bus.o_bit_cnt       = bit_cnt_q;

endmodule

// File: tb/tb_i3c_sda_rx_frontend.sv
// Randomised scoreboard bench for i3c_sda_rx_frontend: bus-level stimulus,
// protocol-level reference model, decoupled event monitor.
module tb_i3c_sda_rx_frontend;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    i3c_sda_rx_frontend_if bus_if ();

    i3c_sda_rx_frontend #(
        .SYNC_STAGES   (2),
        .GLITCH_CYCLES (2)
    ) dut (
        .i_sys_clk (clk),
        .i_sys_rst (rst_n),
        .bus       (bus_if)
    );

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic       st;
        logic       rs;
        logic       sp;
        logic       ab;
        logic       vl;
        logic [7:0] byt;
        logic       nin;
        logic       pe;
        logic       busy;
    } ev_t;

    ev_t        exp_q[$];
    bit         m_busy  = 1'b0;
    bit         m_bits[$];
    logic [7:0] m_byte  = 8'h00;
    logic       m_ninth = 1'b0;

    function automatic void m_push(logic st, logic rs, logic sp, logic ab, logic vl, logic pe);
        ev_t e;
        e = '{st, rs, sp, ab, vl, m_byte, m_ninth, pe, m_busy};
        exp_q.push_back(e);
    endfunction

    // Every SCL rising edge while the bus is busy and capture is enabled is one bit.
    function automatic void m_clock(bit b);
        logic [7:0] v;
        logic       pe;
        if (!bus_if.i_rx_en) begin
            m_bits.delete();
        end else if (m_busy) begin
            m_bits.push_back(b);
            if (m_bits.size() == 9) begin
                v = '0;
                for (int i = 0; i < 8; i++) v = {v[6:0], m_bits[i]};
                m_byte  = v;
                m_ninth = m_bits[8];
                pe = bus_if.i_tbit_mode && (($countones({v, m_bits[8]}) % 2) == 0);
                m_push(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, pe);
                m_bits.delete();
            end
        end
    endfunction

    function automatic void m_sda_fall();
        logic ab;
        ab = m_busy && (m_bits.size() >= 1) && (m_bits.size() <= 8);
        m_bits.delete();
        if (m_busy) begin
            m_push(1'b0, 1'b1, 1'b0, ab, 1'b0, 1'b0);
        end else begin
            m_busy = 1'b1;
            m_push(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        end
    endfunction

    function automatic void m_sda_rise();
        logic ab;
        ab = (m_bits.size() >= 1) && (m_bits.size() <= 8);
        m_bits.delete();
        if (m_busy) begin
            m_busy = 1'b0;
            m_push(1'b0, 1'b0, 1'b1, ab, 1'b0, 1'b0);
        end
    endfunction

    task automatic clks(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic raise_scl();
        m_clock(bus_if.i_sda);
        bus_if.i_scl = 1'b1;
    endtask

    task automatic send_bit(bit b);
        bus_if.i_sda = b;
        clks(4);
        raise_scl();
        clks(8);
        bus_if.i_scl = 1'b0;
        clks(4);
    endtask

    task automatic send_frame(logic [7:0] d, bit t);
        for (int i = 7; i >= 0; i--) send_bit(d[i]);
        send_bit(t);
    endtask

    task automatic do_start();
        if (!(bus_if.i_scl && bus_if.i_sda)) begin
            bus_if.i_sda = 1'b1;
            clks(4);
            raise_scl();
            clks(8);
        end
        m_sda_fall();
        bus_if.i_sda = 1'b0;
        clks(8);
        bus_if.i_scl = 1'b0;
        clks(4);
    endtask

    task automatic do_stop();
        bus_if.i_sda = 1'b0;
        clks(4);
        raise_scl();
        clks(8);
        m_sda_rise();
        bus_if.i_sda = 1'b1;
        clks(8);
    endtask

    // Monitor: every pulse output consumes one expected event.
    always @(negedge clk) begin
        ev_t got;
        ev_t want;
        if (rst_n && (bus_if.o_start_det || bus_if.o_rep_start_det || bus_if.o_stop_det ||
                      bus_if.o_rx_abort || bus_if.o_rx_valid)) begin
            got = '{bus_if.o_start_det, bus_if.o_rep_start_det, bus_if.o_stop_det,
                    bus_if.o_rx_abort, bus_if.o_rx_valid, bus_if.o_rx_byte,
                    bus_if.o_rx_ninth, bus_if.o_parity_err, bus_if.o_bus_busy};
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_event got=%h required=none t=%0t", got, $time);
            end else begin
                want = exp_q.pop_front();
                if (got !== want || bus_if.o_bit_cnt !== 4'd0) begin
                    failures++;
                    $display("FAIL event got=%h bit_cnt=%0d required=%h bit_cnt=0 t=%0t",
                             got, bus_if.o_bit_cnt, want, $time);
                end
            end
        end
    end

    initial begin
        logic [19:0] outs;
        int          lat;
        int          op;
        int          n;

        bus_if.i_sda       = 1'b1;
        bus_if.i_scl       = 1'b1;
        bus_if.i_rx_en     = 1'b1;
        bus_if.i_tbit_mode = 1'b1;

        clks(3);
        outs = {bus_if.o_start_det, bus_if.o_rep_start_det, bus_if.o_stop_det, bus_if.o_bus_busy,
                bus_if.o_rx_byte, bus_if.o_rx_ninth, bus_if.o_rx_valid, bus_if.o_parity_err,
                bus_if.o_rx_abort, bus_if.o_bit_cnt};
        checks++;
        if (outs !== 20'h0) begin
            failures++;
            $display("FAIL reset_state got=%h required=0", outs);
        end
        rst_n = 1'b1;
        clks(4);

        // START latency from the raw SDA edge.
        m_sda_fall();
        bus_if.i_sda = 1'b0;
        lat = 0;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus_if.o_start_det && lat == 0) lat = k;
        end
        checks++;
        if (lat != 5) begin
            failures++;
            $display("FAIL start_latency got=%0d required=5", lat);
        end
        bus_if.i_scl = 1'b0;
        clks(4);

        send_frame(8'hA5, 1'b1);
        send_frame(8'h3C, 1'b1);
        send_frame(8'h01, 1'b0);
        send_frame(8'h01, 1'b1);
        bus_if.i_tbit_mode = 1'b0;
        send_frame(8'h01, 1'b0);
        send_frame(8'h01, 1'b1);
        bus_if.i_tbit_mode = 1'b1;
        do_stop();

        // One-clock SDA glitch on an idle bus must not register.
        bus_if.i_sda = 1'b0;
        clks(1);
        bus_if.i_sda = 1'b1;
        clks(12);

        do_start();
        for (int i = 0; i < 5; i++) send_bit(i[0]);
        do_start();
        send_frame(8'hFF, 1'b1);
        send_frame(8'h7E, 1'b1);
        do_stop();

        // Reset in the middle of a byte.
        do_start();
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        bus_if.i_sda = 1'b1;
        clks(2);
        #3 rst_n = 1'b0;
        #1;
        outs = {bus_if.o_start_det, bus_if.o_rep_start_det, bus_if.o_stop_det, bus_if.o_bus_busy,
                bus_if.o_rx_byte, bus_if.o_rx_ninth, bus_if.o_rx_valid, bus_if.o_parity_err,
                bus_if.o_rx_abort, bus_if.o_bit_cnt};
        checks++;
        if (outs !== 20'h0) begin
            failures++;
            $display("FAIL midbyte_reset got=%h required=0", outs);
        end
        m_busy  = 1'b0;
        m_bits.delete();
        m_byte  = 8'h00;
        m_ninth = 1'b0;
        clks(2);
        rst_n = 1'b1;
        clks(6);
        send_frame(8'h55, 1'b0);

        do_start();
        for (int it = 0; it < 40; it++) begin
            op = $urandom_range(0, 9);
            bus_if.i_tbit_mode = 1'($urandom_range(0, 1));
            case (op)
                0, 1, 2, 3, 4, 5: send_frame(8'($urandom), 1'($urandom_range(0, 1)));
                6: begin
                    n = $urandom_range(1, 8);
                    for (int i = 0; i < n; i++) send_bit(1'($urandom_range(0, 1)));
                    do_start();
                end
                7: begin
                    do_stop();
                    do_start();
                end
                8: begin
                    bus_if.i_rx_en = 1'b0;
                    send_frame(8'($urandom), 1'($urandom_range(0, 1)));
                    bus_if.i_rx_en = 1'b1;
                end
                default: do_start();
            endcase
        end
        do_stop();
        clks(50);

        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL missing_events got=%0d required=0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
